filter_svf_multichannel: RTL

Time-multiplexed Chamberlin state-variable filter serving `CHANNELS` independent voices with one shared registered 18×18 signed multiplier. It sits between the voice mixers and the audio output stage of the SoC audio path. It adds per-channel mode, frequency and Q, saturating integrator state, atomic output update with a valid strobe, and overrun detection. Reset is synchronous.

---
 rtl/svf_pkg.sv | 27 ++
 rtl/svf_mul18x18.sv | 14 +
 rtl/filter_svf_multichannel.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/svf_pkg.sv
// Shared types, fixed-point constants and saturation helpers for the multichannel SVF.
// No timing of its own; no flow control.
package svf_pkg;
   typedef enum logic [2:0] {IDLE, S_Q, S_F, S_H, S_W, DONE} state_t;
   typedef enum logic [1:0] {LP = 2'b00, HP = 2'b01, BP = 2'b10, NOTCH = 2'b11} mode_t;

   localparam int Q1_FRAC = 16;
   localparam int F_FRAC  = 17;
   localparam int MUL_W   = 18;
   localparam int ACC_W   = 40;

   typedef logic signed [ACC_W-1:0] acc_t;

   function automatic acc_t saturate(input acc_t x, input int w);
      acc_t hi;
      acc_t lo;
      hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
      lo = -(acc_t'(1) <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic acc_t clamp(input acc_t x, input int w);
      return saturate(x, w);
   endfunction
endpackage

// File: rtl/svf_mul18x18.sv
// Registered signed 18x18->36 multiplier: product appears one clk after its operands.
// No handshake; it accepts new operands every cycle.
module svf_mul18x18
   import svf_pkg::*;
(
   input  logic                       clk,
   input  logic signed [MUL_W-1:0]    a,
   input  logic signed [MUL_W-1:0]    b,
   output logic signed [2*MUL_W-1:0] p
);
   always_ff @(posedge clk) begin
      p <= a * b;
   end
endmodule

// File: rtl/filter_svf_multichannel.sv
// Time-multiplexed Chamberlin SVF: 4 clk per channel, all outputs update together at E+4*CHANNELS+1.
// No backpressure; a sample edge arriving while busy is dropped and flagged on sticky overrun.
module filter_svf_multichannel
   import svf_pkg::*;
#(
   parameter int SAMPLE_BITS = 12,
   parameter int CHANNELS    = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            sample_clk,
   input  logic [CHANNELS*SAMPLE_BITS-1:0] in,
   input  logic [CHANNELS*2-1:0]           filter_select,
   input  logic [CHANNELS*MUL_W-1:0]       F,
   input  logic [CHANNELS*MUL_W-1:0]       Q1,
   output logic [CHANNELS*SAMPLE_BITS-1:0] out,
   output logic                            out_valid,
   output logic                            overrun
);
   localparam int W  = SAMPLE_BITS + 3;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

   typedef logic signed [W-1:0]           st_t;
   typedef logic signed [SAMPLE_BITS-1:0] smp_t;

   state_t                  state;
   logic                    prev_sample_clk;
   logic                    frame_start;
   logic [CW-1:0]           ch;
   smp_t                    in_l  [CHANNELS];
   logic signed [MUL_W-1:0] f_l   [CHANNELS];
   logic signed [MUL_W-1:0] q_l   [CHANNELS];
   mode_t                   sel_l [CHANNELS];
   st_t                     lp    [CHANNELS];
   st_t                     bp    [CHANNELS];
   st_t                     hp    [CHANNELS];
   st_t                     notch [CHANNELS];
   st_t                     lp_n;
   st_t                     hp_n;
   acc_t                    qb;
   acc_t                    pf;
   acc_t                    lp_c;
   acc_t                    hp_c;
   acc_t                    bp_c;
   acc_t                    notch_c;
   logic signed [MUL_W-1:0]   op_a;
   logic signed [MUL_W-1:0]   op_b;
   logic signed [2*MUL_W-1:0] p;

   function automatic smp_t pick(input mode_t m, input acc_t l, input acc_t h,
                                 input acc_t b, input acc_t n);
      acc_t v;
      case (m)
         LP:      v = l;
         HP:      v = h;
         BP:      v = b;
         default: v = n;
      endcase
      return smp_t'(clamp(v, SAMPLE_BITS));
   endfunction

   svf_mul18x18 u_mul (.clk(clk), .a(op_a), .b(op_b), .p(p));

   assign frame_start = sample_clk & ~prev_sample_clk;

   // p carries F*bp during S_H and F*hp' during S_W; both scale by F_FRAC
   always_comb begin
      pf      = acc_t'(p >>> F_FRAC);
      lp_c    = saturate(acc_t'(lp[ch]) + pf, W);
      hp_c    = saturate(acc_t'(in_l[ch]) - lp_c - qb, W);
      bp_c    = saturate(acc_t'(bp[ch]) + pf, W);
      notch_c = saturate(acc_t'(hp_n) + acc_t'(lp_n), W);
      op_a    = '0;
      op_b    = '0;
      case (state)
         S_Q:     begin op_a = MUL_W'(bp[ch]); op_b = q_l[ch]; end
         S_F:     begin op_a = MUL_W'(bp[ch]); op_b = f_l[ch]; end
         S_H:     begin op_a = MUL_W'(hp_c);   op_b = f_l[ch]; end
         default: begin op_a = '0;             op_b = '0;      end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         prev_sample_clk <= 1'b0;
         ch              <= '0;
         out             <= '0;
         out_valid       <= 1'b0;
         overrun         <= 1'b0;
         qb              <= '0;
         lp_n            <= '0;
         hp_n            <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            in_l[k]  <= '0;
            f_l[k]   <= '0;
            q_l[k]   <= '0;
            sel_l[k] <= LP;
            lp[k]    <= '0;
            bp[k]    <= '0;
            hp[k]    <= '0;
            notch[k] <= '0;
         end
      end else begin
         prev_sample_clk <= sample_clk;
         out_valid       <= 1'b0;
         if (frame_start && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (frame_start) begin
               for (int k = 0; k < CHANNELS; k++) begin
                  in_l[k]  <= in[k*SAMPLE_BITS +: SAMPLE_BITS];
                  f_l[k]   <= F[k*MUL_W +: MUL_W];
                  q_l[k]   <= Q1[k*MUL_W +: MUL_W];
                  sel_l[k] <= mode_t'(filter_select[2*k +: 2]);
               end
               ch    <= '0;
               state <= S_Q;
            end
            S_Q: state <= S_F;
            S_F: begin
               qb    <= acc_t'(p >>> Q1_FRAC);
               state <= S_H;
            end
            S_H: begin
               lp_n  <= st_t'(lp_c);
               hp_n  <= st_t'(hp_c);
               state <= S_W;
            end
            S_W: begin
               lp[ch]    <= lp_n;
               hp[ch]    <= hp_n;
               bp[ch]    <= st_t'(bp_c);
               notch[ch] <= st_t'(notch_c);
               if (ch == LAST) begin
                  // stored state of earlier channels acts as the shadow copy
                  for (int k = 0; k < CHANNELS; k++) begin
                     if (CW'(k) == ch)
                        out[k*SAMPLE_BITS +: SAMPLE_BITS] <= pick(sel_l[k], acc_t'(lp_n),
                           acc_t'(hp_n), bp_c, notch_c);
                     else
                        out[k*SAMPLE_BITS +: SAMPLE_BITS] <= pick(sel_l[k], acc_t'(lp[k]),
                           acc_t'(hp[k]), acc_t'(bp[k]), acc_t'(notch[k]));
                  end
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  ch    <= ch + CW'(1);
                  state <= S_Q;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
